// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry bank, indexed read port.
// Optional key-material clear input enabled by defining AES_KEYSCHED_ZEROIZE_EN.
module aes_key_sched_ctrl #(
  parameter bit          REG_RD = 1'b1,
  parameter int unsigned NR     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  output logic         done,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
`ifdef AES_KEYSCHED_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);

  localparam int unsigned KW  = 128;
  localparam int unsigned NRK = NR + 1;

  if (NR != 10) begin : g_nr_check
    $error("aes_key_sched_ctrl: only NR=10 (AES-128) is supported");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_READY} state_t;

  state_t         state_q, state_d;
  logic           keys_valid_d, done_d;
  logic           accept_c, step_c, clear_c, zero_c;
  logic [KW-1:0]  w_q;
  logic [3:0]     cnt_q;
  logic [7:0]     rcon_q;
  logic [KW-1:0]  rk_q [NRK];
  logic [31:0]    t_c, n0_c, n1_c, n2_c, n3_c;
  logic [KW-1:0]  nxt_c;
  logic [7:0]     xtime_c;
  logic [KW-1:0]  rd_mux_c;

`ifdef AES_KEYSCHED_ZEROIZE_EN
  assign zero_c = zeroize;
`else
  assign zero_c = 1'b0;
`endif

  // State register and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_ready  <= (state_d != ST_EXPAND);
      busy       <= (state_d == ST_EXPAND);
      keys_valid <= keys_valid_d;
      done       <= done_d;
    end
  end

  // Next state; zeroize overrides everything including a simultaneous key accept
  always_comb begin
    state_d      = state_q;
    keys_valid_d = keys_valid;
    done_d       = 1'b0;
    accept_c     = 1'b0;
    step_c       = 1'b0;
    clear_c      = 1'b0;
    if (zero_c) begin
      clear_c      = 1'b1;
      state_d      = ST_IDLE;
      keys_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (key_valid && key_ready) begin
            accept_c     = 1'b1;
            state_d      = ST_EXPAND;
            keys_valid_d = 1'b0;
          end
        end
        ST_EXPAND: begin
          step_c = 1'b1;
          if (cnt_q == 4'(NR)) begin
            state_d      = ST_READY;
            keys_valid_d = 1'b1;
            done_d       = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // One AES-128 expansion round from the working key
  always_comb begin
    t_c     = {sbox(w_q[23:16]), sbox(w_q[15:8]), sbox(w_q[7:0]), sbox(w_q[31:24])}
              ^ {rcon_q, 24'h0};
    n0_c    = w_q[127:96] ^ t_c;
    n1_c    = n0_c ^ w_q[95:64];
    n2_c    = n1_c ^ w_q[63:32];
    n3_c    = n2_c ^ w_q[31:0];
    nxt_c   = {n0_c, n1_c, n2_c, n3_c};
    xtime_c = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
  end

  // Working key, round counter, rcon and round-key bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q    <= '0;
      cnt_q  <= '0;
      rcon_q <= 8'h01;
      for (int unsigned i = 0; i < NRK; i++) rk_q[i] <= '0;
    end else if (clear_c) begin
      w_q    <= '0;
      cnt_q  <= '0;
      rcon_q <= 8'h01;
      for (int unsigned i = 0; i < NRK; i++) rk_q[i] <= '0;
    end else if (accept_c) begin
      rk_q[0] <= key_in;
      w_q     <= key_in;
      cnt_q   <= 4'd1;
      rcon_q  <= 8'h01;
    end else if (step_c) begin
      for (int unsigned i = 1; i < NRK; i++) begin
        if (cnt_q == 4'(i)) rk_q[i] <= nxt_c;
      end
      w_q    <= nxt_c;
      cnt_q  <= cnt_q + 4'd1;
      rcon_q <= xtime_c;
    end
  end

  // Out-of-range indices read as zero
  always_comb begin
    rd_mux_c = '0;
    for (int unsigned i = 0; i < NRK; i++) begin
      if (rd_round == 4'(i)) rd_mux_c = rk_q[i];
    end
  end

  if (REG_RD) begin : g_rd_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst)          rd_key <= '0;
      else if (clear_c) rd_key <= '0;
      else              rd_key <= rd_mux_c;
    end
  end else begin : g_rd_comb
    assign rd_key = rd_mux_c;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Iterative, sequenced AES-128 key scheduler that replaces the fully unrolled combinational expansion with one round per clock. It uses a single g-function datapath (4 S-box lookups, RotWord, Rcon XOR) and stores the 11 round keys in an internal register bank. The cipher round controller reads keys through an indexed read port. The block sits between the key-load interface and the encrypt/decrypt round engine.

Parameters:
REG_RD, 1, 1 = registered read port with 1-cycle latency; 0 = combinational read.
NR, 10, number of rounds; only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
key_in  input  128  cipher key, {w0,w1,w2,w3}, with w0 at [127:96].
key_valid  input  1  key_in is valid; load request.
key_ready  output  1  block can accept a key; high when state != EXPAND.
busy  output  1  expansion in progress; high in state EXPAND.
keys_valid  output  1  all 11 round keys are stable and readable.
done  output  1  one-cycle pulse when expansion completes.
rd_round  input  4  round-key index to read, 0..10.
rd_key  output  128  round key rk[rd_round].
zeroize  input  1  present only with AES_KEYSCHED_ZEROIZE_EN; clears key material.

Behaviour:
- Reset (async, rst=1): state=IDLE; rk[0..10]=0; working reg w=0; cnt=0; rcon=8'h01; key_ready=1, busy=0, keys_valid=0, done=0, rd_key=0.
- States: IDLE, EXPAND, READY.
- Key accept: on a rising edge with key_valid && key_ready, in IDLE or READY:
  - rk[0]=key_in, w=key_in, cnt=1, rcon=8'h01.
  - keys_valid=0, state=EXPAND.
- EXPAND, each cycle:
  - t = {SB(w3[23:16]), SB(w3[15:8]), SB(w3[7:0]), SB(w3[31:24])} ^ {rcon, 24'h0}.
  - n0 = w0^t; n1 = n0^w1; n2 = n1^w2; n3 = n2^w3.
  - rk[cnt]={n0,n1,n2,n3}; w={n0,n1,n2,n3}; cnt=cnt+1; rcon=xtime(rcon), where xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- Completion: the edge that writes rk[10] (cnt==10) moves state to READY and sets keys_valid=1 and done=1. done clears on the next edge.
- Latency: accept edge E0; rk[i] written at edge E0+i; keys_valid and done are visible after edge E0+10.
- key_valid during EXPAND: ignored (key_ready=0). No queuing; the requester must hold key_valid.
- Key accept in READY: allowed. keys_valid drops after the accept edge, and rk[1..10] keep stale values until overwritten.
- Read port:
  - REG_RD=1: rd_key registered from rk[rd_round] each edge.
  - REG_RD=0: rd_key = rk[rd_round] combinationally.
  - rd_round 11..15 returns 128'h0.
  - Reads are legal at any time; data is guaranteed only while keys_valid=1.
- Reset mid-EXPAND: immediate return to reset values; the partial schedule is lost.

Optional Feature:
- Macro: AES_KEYSCHED_ZEROIZE_EN.
- With the macro defined:
  - The zeroize port exists.
  - zeroize=1 at an edge clears rk[0..10], w, cnt, keys_valid and done, sets rcon=01, and sets state=IDLE, regardless of state.
  - zeroize takes priority over a simultaneous key accept.
  - With REG_RD=1, rd_key reads 0 on the following edge.
- Without the macro: the port is absent and key material is cleared only by rst.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted -> busy for 10 cycles, done pulse at E0+10. Required values: rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key -> rk[1]=62636363626363636263636362636363 and rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- key_valid held high throughout EXPAND with a different key -> ignored. Results match the first key, and the second key is accepted only in READY.
- rst asserted at E0+5 -> all outputs go to zero immediately, key_ready=1; reload gives correct keys after 10 cycles.
- Read port with REG_RD=1 -> rd_round=4 gives rk[4] one cycle later; rd_round=12 gives 0. With REG_RD=0 -> same cycle.
- With AES_KEYSCHED_ZEROIZE_EN: zeroize together with key_valid in READY -> state IDLE, keys_valid=0, all rk reads 0, no expansion starts.
